// File: rtl/matrix_ctrl_pkg.sv
// Shared definitions for the matrix operation controller:
// state encoding, opcode constants and instruction field layout.
package matrix_ctrl_pkg;

   localparam int DATA_W  = 200;
   localparam int MADDR_W = 8;

   localparam logic [2:0] OP_HALT   = 3'b111;
   localparam logic [2:0] OP_SCALAR = 3'b011;
   localparam logic [2:0] OP_UN_LO  = 3'b100;
   localparam logic [2:0] OP_UN_HI  = 3'b110;

   localparam int F_OP   = 0;
   localparam int F_A    = 3;
   localparam int F_B    = 11;
   localparam int F_DST  = 19;
   localparam int F_SIZE = 27;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_READ_A,
      S_READ_B,
      S_EXEC,
      S_WRITE,
      S_HALT
   } state_e;

   typedef struct packed {
      logic [2:0]         op;
      logic [MADDR_W-1:0] addr_a;
      logic [MADDR_W-1:0] addr_b;
      logic [MADDR_W-1:0] addr_dst;
      logic [1:0]         size;
   } instr_t;

   // Unary opcodes skip the second operand read.
   function automatic logic is_unary(input logic [2:0] op);
      return (op >= OP_UN_LO) && (op <= OP_UN_HI);
   endfunction

endpackage

// File: rtl/matrix_op_controller_decoder.sv
// Instruction field extraction and opcode classification.
// Bits [31:29] of the instruction word carry no meaning.
module instr_decoder
   import matrix_ctrl_pkg::*;
(
   input  logic [31:0] instr_i,
   output instr_t      fields_o,
   output logic        halt_o,
   output logic        unary_o
);

   logic unused_hi;

   assign fields_o.op       = instr_i[F_OP +: 3];
   assign fields_o.addr_a   = instr_i[F_A +: MADDR_W];
   assign fields_o.addr_b   = instr_i[F_B +: MADDR_W];
   assign fields_o.addr_dst = instr_i[F_DST +: MADDR_W];
   assign fields_o.size     = instr_i[F_SIZE +: 2];
   assign halt_o            = (fields_o.op == OP_HALT);
   assign unary_o           = is_unary(fields_o.op);
   assign unused_hi         = ^instr_i[31:29];

endmodule

// File: rtl/matrix_op_controller.sv
// Sequencer that fetches matrix instructions, reads operands,
// drives the execute stage and writes results back.
// Optional run statistics: define MATRIX_CTRL_PERF_EN.
module matrix_op_controller
   import matrix_ctrl_pkg::*;
#(
   parameter int EXEC_LAT = 2,
   parameter int PC_W     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [PC_W-1:0]     start_pc,
   output logic                busy,
   output logic                done,
   output logic [PC_W-1:0]     instr_addr,
   input  logic [31:0]         instr_data,
   output logic [MADDR_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [2:0]          opcode,
   output logic [DATA_W-1:0]   operand_a,
   output logic [DATA_W-1:0]   operand_b,
   output logic [7:0]          matriz_size,
   input  logic [DATA_W-1:0]   result
`ifdef MATRIX_CTRL_PERF_EN
   ,
   output logic [15:0]         instr_count,
   output logic [31:0]         cycle_count
`endif
);

   localparam logic [3:0] LAT_M1 = 4'(EXEC_LAT - 1);
   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   instr_t              ir_q, ir_d;
   logic                unary_q, unary_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   a_q, b_q;
   logic                pend_a_q, pend_b_q;
   instr_t              dec;
   logic                dec_halt, dec_unary;

   instr_decoder u_dec (
      .instr_i  (instr_data),
      .fields_o (dec),
      .halt_o   (dec_halt),
      .unary_o  (dec_unary)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state sequencing.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = dec_halt ? S_HALT : S_READ_A;
         S_READ_A: state_d = unary_q ? S_EXEC : S_READ_B;
         S_READ_B: state_d = S_EXEC;
         S_EXEC:   if (cnt_q == 4'd0) state_d = S_WRITE;
         S_WRITE:  state_d = S_FETCH;
         S_HALT:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Next values for pc, instruction register and EXEC counter.
   always_comb begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      unary_d = unary_q;
      cnt_d   = cnt_q;
      if (state_q == S_IDLE && start) pc_d = start_pc;
      if (state_q == S_WRITE) pc_d = pc_q + PC_ONE;
      if (state_q == S_DECODE) begin
         ir_d    = dec;
         unary_d = dec_unary;
      end
      if (state_q == S_EXEC) begin
         if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end else if (state_d == S_EXEC) begin
         cnt_d = LAT_M1;
      end
   end

   // Datapath registers; read data is captured the cycle after its address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q     <= '0;
         ir_q     <= '0;
         unary_q  <= 1'b0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         pend_a_q <= 1'b0;
         pend_b_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         unary_q  <= unary_d;
         cnt_q    <= cnt_d;
         pend_a_q <= (state_q == S_READ_A);
         pend_b_q <= (state_q == S_READ_B);
         if (pend_a_q) a_q <= mem_rdata;
         if (state_q == S_DECODE) b_q <= '0;
         else if (pend_b_q)       b_q <= mem_rdata;
      end
   end

   // Output decode; the freshest operand comes straight from memory.
   always_comb begin
      busy        = (state_q != S_IDLE);
      done        = 1'b0;
      instr_addr  = '0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      opcode      = OP_HALT;
      operand_a   = '0;
      operand_b   = '0;
      matriz_size = '0;
      unique case (state_q)
         S_FETCH:  instr_addr = pc_q;
         S_READ_A: mem_addr = ir_q.addr_a;
         S_READ_B: mem_addr = ir_q.addr_b;
         S_EXEC: begin
            opcode      = ir_q.op;
            operand_a   = pend_a_q ? mem_rdata : a_q;
            operand_b   = pend_b_q ? mem_rdata : b_q;
            matriz_size = 8'(ir_q.size) + 8'd2;
         end
         S_WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = ir_q.addr_dst;
            mem_wdata = result;
         end
         S_HALT:  done = 1'b1;
         default: ;
      endcase
   end

`ifdef MATRIX_CTRL_PERF_EN
   logic [15:0] icnt_q;
   logic [31:0] ccnt_q;

   // Saturating per-run instruction and busy-cycle counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         icnt_q <= '0;
         ccnt_q <= '0;
      end else if (state_q == S_IDLE && start) begin
         icnt_q <= '0;
         ccnt_q <= '0;
      end else begin
         if (state_q == S_WRITE && icnt_q != '1) icnt_q <= icnt_q + 16'd1;
         if (state_q != S_IDLE && ccnt_q != '1) ccnt_q <= ccnt_q + 32'd1;
      end
   end

   assign instr_count = icnt_q;
   assign cycle_count = ccnt_q;
`endif

endmodule

// File: tb/tb_matrix_op_controller.sv
// Randomized scoreboard bench for matrix_op_controller.
// Builds with or without MATRIX_CTRL_PERF_EN.
module tb_matrix_op_controller;

   localparam int LAT = 2;

   typedef struct {
      logic [2:0]   op;
      logic [199:0] a;
      logic [199:0] b;
      logic [7:0]   sz;
      logic [7:0]   dst;
      logic [199:0] data;
   } exp_t;

   logic         clk, reset, start;
   logic [7:0]   start_pc;
   logic         busy, done;
   logic [7:0]   instr_addr;
   logic [31:0]  instr_data;
   logic [7:0]   mem_addr;
   logic [199:0] mem_rdata;
   logic         mem_we;
   logic [199:0] mem_wdata;
   logic [2:0]   opcode;
   logic [199:0] operand_a, operand_b;
   logic [7:0]   matriz_size;
   logic [199:0] result;
`ifdef MATRIX_CTRL_PERF_EN
   logic [15:0]  instr_count;
   logic [31:0]  cycle_count;
`endif

   logic [199:0] mem  [256];
   logic [199:0] mm   [256];
   logic [31:0]  rom  [256];
   logic [199:0] pipe [LAT];
   logic         init_go;
   exp_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   int           wr_seen = 0;
   int           meas;

   matrix_op_controller #(.EXEC_LAT(LAT), .PC_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_pc    (start_pc),
      .busy        (busy),
      .done        (done),
      .instr_addr  (instr_addr),
      .instr_data  (instr_data),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .opcode      (opcode),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .matriz_size (matriz_size),
      .result      (result)
`ifdef MATRIX_CTRL_PERF_EN
      ,
      .instr_count (instr_count),
      .cycle_count (cycle_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in execute stage: arbitrary mixing function, LAT-deep pipe.
   function automatic logic [199:0] exe(input logic [2:0] op,
                                        input logic [199:0] a,
                                        input logic [199:0] b,
                                        input logic [7:0] sz);
      return (a ^ {b[150:0], b[199:151]}) + 200'({op, sz});
   endfunction

   always @(posedge clk) begin
      pipe[0] <= exe(opcode, operand_a, operand_b, matriz_size);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign result = pipe[LAT-1];

   // Instruction ROM and matrix memory, both 1-cycle read latency.
   always @(posedge clk) begin
      instr_data <= rom[instr_addr];
      mem_rdata  <= mem[mem_addr];
      if (init_go) begin
         for (int i = 0; i < 256; i++) mem[i] <= mm[i];
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [199:0] act,
                      input logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [199:0] rnd200();
      logic [199:0] v;
      v = '0;
      for (int i = 0; i < 7; i++) v = {v[167:0], $urandom()};
      return v;
   endfunction

   function automatic logic [31:0] mk(input logic [2:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic [7:0] d,
                                      input logic [1:0] sz);
      logic [2:0] junk;
      junk = 3'($urandom());
      return {junk, sz, d, b, a, op};
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < 256; i++) mm[i] = rnd200();
   endtask

   task automatic load_mem();
      @(negedge clk);
      init_go = 1'b1;
      @(negedge clk);
      init_go = 1'b0;
   endtask

   // Reference: walk the program, push expected writes, total cycles.
   task automatic model(input logic [7:0] spc, output int cyc,
                        output int nins);
      logic [7:0]  pc;
      logic [31:0] w;
      exp_t        e;
      cyc  = 1;
      nins = 0;
      pc   = spc;
      for (int k = 0; k < 64; k++) begin
         w = rom[pc];
         if (w[2:0] == 3'b111) begin
            cyc += 3;
            break;
         end
         e.op   = w[2:0];
         e.a    = mm[w[10:3]];
         e.b    = (w[2:0] <= 3'd3) ? mm[w[18:11]] : '0;
         e.sz   = 8'(w[28:27]) + 8'd2;
         e.dst  = w[26:19];
         e.data = exe(e.op, e.a, e.b, e.sz);
         sb.push_back(e);
         mm[e.dst] = e.data;
         cyc += (e.op <= 3'd3) ? 5 + LAT : 4 + LAT;
         nins++;
         pc = pc + 8'd1;
      end
   endtask

   // Monitor: operands during EXEC and every memory write.
   always @(negedge clk) begin
      if (!reset) begin
         if (opcode != 3'b111) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL exec_unexpected op %0d", opcode);
            end else if (opcode !== sb[0].op || operand_a !== sb[0].a ||
                         operand_b !== sb[0].b ||
                         matriz_size !== sb[0].sz) begin
               errors++;
               $display("FAIL exec_ops op %0d/%0d sz %0d/%0d b %h/%h",
                        opcode, sb[0].op, matriz_size, sb[0].sz,
                        operand_b, sb[0].b);
            end
         end
         if (mem_we) begin
            exp_t e;
            checks++;
            wr_seen++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected addr %h", mem_addr);
            end else begin
               e = sb.pop_front();
               if (mem_addr !== e.dst || mem_wdata !== e.data) begin
                  errors++;
                  $display("FAIL write addr %h/%h data %h/%h",
                           mem_addr, e.dst, mem_wdata, e.data);
               end
            end
         end
      end
   end

   task automatic run_prog(input logic [7:0] spc, input bit pulse,
                           output int m);
      int ecyc, nins, cnt;
      model(spc, ecyc, nins);
      @(negedge clk);
      start    = 1'b1;
      start_pc = spc;
      cnt      = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (pulse && cnt == 2) begin
            start    = 1'b1;
            start_pc = spc + 8'h40;
         end else begin
            start = 1'b0;
         end
      end while (!done && cnt < 3000);
      start = 1'b0;
      chk("done_seen", done, 1'b1);
      m = cnt + 1;
      chk("run_cycles", m, ecyc);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("idle_after_halt", busy, 1'b0);
`ifdef MATRIX_CTRL_PERF_EN
      chk("instr_count", instr_count, nins);
      chk("cycle_count", cycle_count, m - 1);
`endif
      repeat (2) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic reset_mid();
      int n, w0;
      fill_rand();
      load_mem();
      rom[8'h60] = mk(3'd0, 8'h21, 8'h22, 8'h23, 2'd0);
      rom[8'h61] = mk(3'd1, 8'h23, 8'h24, 8'h25, 2'd3);
      rom[8'h62] = mk(3'd2, 8'h25, 8'h26, 8'h27, 2'd1);
      rom[8'h63] = mk(3'd7, 8'h00, 8'h00, 8'h00, 2'd0);
      model(8'h60, n, w0);
      w0 = wr_seen;
      @(negedge clk);
      start    = 1'b1;
      start_pc = 8'h60;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(wr_seen == w0 + 1 && opcode != 3'b111) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reached_exec2", n < 200, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_opcode", opcode, 3'b111);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_opb", operand_b, '0);
      chk("rst_size", matriz_size, '0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_stays_idle", busy, 1'b0);
      chk("rst_no_write", wr_seen, w0 + 1);
   endtask

   initial begin
      logic [7:0] spc, pa, pd;
      int         nn;
      reset    = 1'b1;
      start    = 1'b0;
      start_pc = '0;
      init_go  = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 32'h7;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_we", mem_we, 1'b0);
      chk("reset_opcode", opcode, 3'b111);
      chk("reset_opa", operand_a, '0);
      chk("reset_wdata", mem_wdata, '0);
      chk("reset_iaddr", instr_addr, '0);
      chk("reset_maddr", mem_addr, '0);
      reset = 1'b0;
      @(negedge clk);

      fill_rand();
      load_mem();
      rom[8'h10] = mk(3'd0, 8'h01, 8'h02, 8'h03, 2'd1);
      rom[8'h11] = mk(3'd7, 8'h00, 8'h00, 8'h00, 2'd0);
      run_prog(8'h10, 1'b0, meas);
      chk("add_11_cycles", meas, 11);

      fill_rand();
      load_mem();
      rom[8'h20] = mk(3'd4, 8'h07, 8'h08, 8'h09, 2'd2);
      rom[8'h21] = mk(3'd7, 8'h00, 8'h00, 8'h00, 2'd0);
      run_prog(8'h20, 1'b0, meas);
      chk("unary_10_cycles", meas, 10);

      fill_rand();
      mm[8'h05][7:0] = 8'hFE;
      load_mem();
      rom[8'h30] = mk(3'd3, 8'h04, 8'h05, 8'h06, 2'd3);
      rom[8'h31] = mk(3'd7, 8'h00, 8'h00, 8'h00, 2'd0);
      run_prog(8'h30, 1'b0, meas);

      fill_rand();
      load_mem();
      rom[8'h40] = mk(3'd0, 8'h10, 8'h11, 8'h30, 2'd0);
      rom[8'h41] = mk(3'd5, 8'h30, 8'h00, 8'h31, 2'd1);
      rom[8'h42] = mk(3'd1, 8'h31, 8'h30, 8'h32, 2'd2);
      rom[8'h43] = mk(3'd7, 8'h00, 8'h00, 8'h00, 2'd0);
      run_prog(8'h40, 1'b0, meas);

      fill_rand();
      load_mem();
      rom[8'hFF] = mk(3'd2, 8'h01, 8'h02, 8'h50, 2'd2);
      rom[8'h00] = mk(3'd7, 8'h00, 8'h00, 8'h00, 2'd0);
      run_prog(8'hFF, 1'b1, meas);
      chk("wrap_cycles", meas, 11);

      reset_mid();

      for (int t = 0; t < 20; t++) begin
         spc = 8'($urandom());
         nn  = $urandom_range(0, 4);
         pd  = 8'($urandom());
         for (int i = 0; i < nn; i++) begin
            pa = ($urandom_range(0, 2) == 0) ? pd : 8'($urandom());
            pd = 8'($urandom());
            rom[spc + 8'(i)] = mk(3'($urandom_range(0, 6)), pa,
                                  8'($urandom()), pd,
                                  2'($urandom()));
         end
         rom[spc + 8'(nn)] = mk(3'd7, 8'($urandom()), 8'($urandom()),
                                8'($urandom()), 2'($urandom()));
         fill_rand();
         load_mem();
         run_prog(spc, 1'($urandom_range(0, 1)), meas);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_op_controller.md
MATRIX_OP_CONTROLLER -- requirements
Module: matrix_op_controller

Interface
REQ-001 SHALL have parameter EXEC_LAT, default 2: cycles from operand issue to a valid execute-stage result (legal range 1..15).
REQ-002 SHALL have parameter PC_W, default 8: instruction address width.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: run request, sampled in IDLE.
REQ-006 SHALL have port start_pc, input, PC_W: first instruction address.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse on the HALT state exit.
REQ-009 SHALL have ports instr_addr, output, PC_W, and instr_data, input, 32: instruction ROM with 1-cycle read latency.
REQ-010 SHALL have ports mem_addr, output, 8; mem_rdata, input, 200; mem_we, output, 1; mem_wdata, output, 200: matrix memory with 1-cycle read latency.
REQ-011 SHALL have ports opcode, output, 3; operand_a, output, 200; operand_b, output, 200; matriz_size, output, 8; result, input, 200: execute-stage connection.

Function
REQ-012 SHALL decode instr_data as: [2:0] opcode, [10:3] addr_a, [18:11] addr_b, [26:19] addr_dst, [28:27] size code; all other bits are ignored.
REQ-013 SHALL drive matriz_size = size code + 2, giving 2..5.
REQ-014 SHALL implement states IDLE, FETCH, DECODE, READ_A, READ_B, EXEC, WRITE, HALT.
REQ-015 SHALL go IDLE->FETCH when start=1, loading pc with start_pc; start is ignored while busy=1.
REQ-016 SHALL drive instr_addr=pc in FETCH, then capture the instruction in DECODE.
REQ-017 SHALL go DECODE->HALT for opcode 111, and DECODE->READ_A for any other opcode.
REQ-018 SHALL go READ_A->READ_B for opcodes 000..011, and READ_A->EXEC for opcodes 100..110 with operand_b forced to 0.
REQ-019 SHALL drive mem_addr=addr_a in READ_A and mem_addr=addr_b in READ_B, latching mem_rdata one cycle later.
REQ-020 SHALL pass the full 200-bit word on operand_b for opcode 011; the execute stage uses bits [7:0] as the signed scalar.
REQ-021 SHALL hold opcode, operand_a, operand_b and matriz_size stable through EXEC, which lasts exactly EXEC_LAT cycles (down-counter).
REQ-022 SHALL in WRITE assert mem_we=1 for one cycle with mem_addr=addr_dst and mem_wdata=result, increment pc (wrapping modulo 2^PC_W), then go to FETCH.
REQ-023 SHALL in HALT pulse done for one cycle and return to IDLE.
REQ-024 SHALL drive opcode=111 (no-op to the execute stage) whenever the state is not EXEC.
REQ-025 SHALL keep mem_we=0 in every state except WRITE.
REQ-026 SHALL give an instruction with a read-back-after-write hazard (addr_a equal to the previous addr_dst) the new data, because the write completes before the next FETCH.

Reset
REQ-027 SHALL on reset=1 immediately force state=IDLE, pc=0, busy=0, done=0, mem_we=0, opcode=111, all data outputs to 0 and the EXEC counter to 0.
REQ-028 SHALL abandon a mid-program reset with no write; an in-flight WRITE cycle is suppressed at the moment reset asserts.

Configuration
REQ-029 SHALL, with MATRIX_CTRL_PERF_EN defined, add outputs instr_count (16 bits, incremented per WRITE) and cycle_count (32 bits, incremented while busy); both clear on reset and on IDLE->FETCH, and saturate at all-ones.
REQ-030 SHALL, without MATRIX_CTRL_PERF_EN, have neither these ports nor their counters.

Structure
REQ-031 SHALL take state encoding, opcode constants (OP_HALT=111, OP_SCALAR=011, unary range 100..110) and instruction field positions from a shared package, matrix_ctrl_pkg.
REQ-032 SHALL use no sub-module, except an optional instr_decoder holding the field extraction and opcode classification.

Verification
REQ-033 Run [ADD A=0x01,B=0x02,D=0x03,size 3; HALT] with EXEC_LAT=2 -> one mem_we at addr 0x03 with mem_wdata=result; done pulses; 11 cycles from start to done.
REQ-034 Unary opcode 100 -> no READ_B cycle, operand_b=0, write takes 1 cycle less than a binary opcode.
REQ-035 Scalar opcode 011 with mem word at addr_b whose low byte is 0xFE -> operand_b[7:0]=0xFE held for the whole of EXEC.
REQ-036 Assert reset during EXEC of the second instruction -> outputs take reset values within the same cycle, no mem_we, IDLE reached, a later start runs normally.
REQ-037 start pulsed while busy; start_pc=0xFF with a non-halt instruction at 0xFF -> second start ignored; pc wraps to 0x00.
REQ-038 With MATRIX_CTRL_PERF_EN, a 3-instruction program -> instr_count=3 and cycle_count equal to the busy-cycle count.
